sram_d_arbiter: RTL and testbench
=================================

# sram_d_arbiter

Two-master OBI arbiter placed directly upstream of the SRAM wrapper's data port; it produces the "muxed" `sram_d_*` request stream. Master 0 is the core data port and master 1 is the DMA/debug port. The block round-robins between them and range-checks every address against the SRAM window. Out-of-window requests are answered locally with an error response and logged; they are never forwarded to the SRAM.

## Interface
Parameters:
- `SRAM_BASE_ADDR`, 32'h8000_0000: first legal byte address (inclusive).
- `SRAM_END_ADDR`, 32'h8000_C000: end of the legal window (exclusive).

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: reset, synchronous and active-low.
- `m0_req_i` in 1, `m0_gnt_o` out 1: master 0 request/grant.
- `m0_addr_i` in 32, `m0_we_i` in 1, `m0_be_i` in 4, `m0_wdata_i` in 32: master 0 request payload.
- `m0_rvalid_o` out 1, `m0_rdata_o` out 32, `m0_err_o` out 1: master 0 response.
- `m1_*`: same set as `m0_*`, for master 1.
- `sram_d_req_o` out 1, `sram_d_gnt_i` in 1: downstream request/grant.
- `sram_d_addr_o` out 32, `sram_d_we_o` out 1, `sram_d_be_o` out 4, `sram_d_wdata_o` out 32: downstream request payload.
- `sram_d_rvalid_i` in 1, `sram_d_rdata_i` in 32: downstream response.
- `illegal_memory_o` out 1: one-cycle pulse when an error response is delivered.
- `err_addr_o` out 32: address of the most recent illegal request.
- `err_count_o` out 8: count of illegal requests, saturating.

## Operation
- Legal address: `SRAM_BASE_ADDR <= addr < SRAM_END_ADDR`, unsigned 32-bit compare.
- Winner selection is combinational:
  - Only one `req` high: that master wins.
  - Both high: the master not equal to `last_q` wins.
  - `last_q` resets to 1, so master 0 wins the first tie.
- Legal winner:
  - Payload is forwarded and `sram_d_req_o=1`.
  - Winner gnt = `sram_d_gnt_i`.
- Illegal winner:
  - `sram_d_req_o=0`; winner gnt = 1 (local accept).
- Loser gnt = 0. Neither master requesting gives all gnts 0.
- While no legal request is forwarded, `sram_d_addr/we/be/wdata_o` = 0.
- A handshake is the winner's req && gnt. On a handshake:
  - `last_q` <= winner.
  - `resp_valid_q` <= 1, `resp_id_q` <= winner, `resp_err_q` <= illegal.
- No handshake: `resp_valid_q` <= 0.
- Response cycle, when `resp_valid_q=1`, goes to master `resp_id_q`:
  - `resp_err_q=1`: rvalid=1, err=1, rdata=0, `illegal_memory_o`=1.
  - `resp_err_q=0`: rvalid=`sram_d_rvalid_i`, rdata=`sram_d_rdata_i`, err=0.
- The non-addressed master always sees rvalid=0, rdata=0, err=0.
- `sram_d_rvalid_i` while `resp_valid_q=0` is ignored.
- Error log, updated on an illegal handshake:
  - `err_addr_o` <= request addr.
  - `err_count_o` <= min(`err_count_o`+1, 255).

## Timing
- Grant is combinational, in the same cycle as req. Response latency is exactly 1 cycle after the handshake, for both legal and illegal requests. This matches the SRAM wrapper's fixed 1-cycle rvalid.
- Back-to-back handshakes are allowed every cycle. At most one response is outstanding, so no FIFO is needed.
- Reset values: `last_q`=1, `resp_valid_q`=0, all rvalid/err/rdata=0, `illegal_memory_o`=0, `err_addr_o`=0, `err_count_o`=0.
- Under reset the gnts stay combinational, but all registers are held at their reset values.
- Reset asserted the cycle after a handshake drops that response. Any `sram_d_rvalid_i` in that cycle is ignored.
- Simultaneous illegal request from one master and legal request from the other: the round-robin decides, and the loser waits.
- Back-to-back handshakes: a response delivery and a new handshake may coincide. The registers reload for the new handshake.
- `err_count_o` stays at 255 on further illegal requests; `err_addr_o` still updates.
- Boundary addresses:
  - addr = `SRAM_END_ADDR`-4 is legal.
  - addr = `SRAM_END_ADDR` is illegal.
  - addr = `SRAM_BASE_ADDR`-4 is illegal.

## Test plan
- **Single master read:** m0 reads 0x8000_0010; stub SRAM returns 0x1234_5678 one cycle later. Required: `m0_gnt_o`=1 in the same cycle, `m0_rvalid_o`=1 with 0x1234_5678 the next cycle, all m1 outputs 0.
- **Contention:** both masters hold req for 4 cycles, both legal. Required: grants alternate m0, m1, m0, m1, and each response is routed to the matching master with the stub's per-address data.
- **Illegal access:** m1 writes 0x8000_C000. Required:
  - `sram_d_req_o`=0 and `m1_gnt_o`=1.
  - Next cycle: `m1_rvalid_o`=1, `m1_err_o`=1, rdata 0, `illegal_memory_o`=1.
  - `err_addr_o`=0x8000_C000 and `err_count_o`=1.
- **Window edges:** 0x8000_BFFC is forwarded; 0x7FFF_FFFC errors. 300 illegal requests leave `err_count_o`=255.
- **Downstream stall:** `sram_d_gnt_i`=0 for 3 cycles with m0 requesting. Required: no handshake and no rvalid. Grant, handshake and response follow once `sram_d_gnt_i` returns to 1.
- **Reset mid-flight:** assert `rst_ni`=0 the cycle after a legal handshake, with stub rvalid=1 in that cycle. Required: no master rvalid, and `last_q` back to 1, so m0 wins the next tie.

Source files
------------

// File: rtl/sram_d_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sram_d_arbiter
//
// Two-master OBI arbiter feeding the SRAM wrapper's data port. Master 0 is the
// core data port, master 1 the DMA/debug port. The two are served round-robin.
// Every address is range-checked against [SRAM_BASE_ADDR, SRAM_END_ADDR).
// Out-of-window requests are never forwarded. They are accepted locally,
// answered one cycle later with an error response, and logged.
//
// Ports
//   clk_i, rst_ni                    clock, synchronous active-low reset
//   m{0,1}_req_i / m{0,1}_gnt_o      master request / grant (grant is combinational)
//   m{0,1}_addr/we/be/wdata_i        master request payload
//   m{0,1}_rvalid/rdata/err_o        master response, 1 cycle after handshake
//   sram_d_req_o / sram_d_gnt_i      downstream request / grant
//   sram_d_addr/we/be/wdata_o        downstream payload (zero when idle)
//   sram_d_rvalid_i, sram_d_rdata_i  downstream response
//   illegal_memory_o                 pulse while an error response is delivered
//   err_addr_o, err_count_o          last illegal address, saturating count
// -----------------------------------------------------------------------------
module sram_d_arbiter #(
   parameter logic [31:0] SRAM_BASE_ADDR = 32'h8000_0000,
   parameter logic [31:0] SRAM_END_ADDR  = 32'h8000_C000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   // master 0
   input  logic        m0_req_i,
   output logic        m0_gnt_o,
   input  logic [31:0] m0_addr_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_be_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_rvalid_o,
   output logic [31:0] m0_rdata_o,
   output logic        m0_err_o,
   // master 1
   input  logic        m1_req_i,
   output logic        m1_gnt_o,
   input  logic [31:0] m1_addr_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_be_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_rvalid_o,
   output logic [31:0] m1_rdata_o,
   output logic        m1_err_o,
   // downstream SRAM port
   output logic        sram_d_req_o,
   input  logic        sram_d_gnt_i,
   output logic [31:0] sram_d_addr_o,
   output logic        sram_d_we_o,
   output logic [3:0]  sram_d_be_o,
   output logic [31:0] sram_d_wdata_o,
   input  logic        sram_d_rvalid_i,
   input  logic [31:0] sram_d_rdata_i,
   // error log
   output logic        illegal_memory_o,
   output logic [31:0] err_addr_o,
   output logic [7:0]  err_count_o
);

   logic        m0_legal, m1_legal;
   logic        win_id;      // 0 = master 0, 1 = master 1
   logic        win_req;
   logic        win_legal;
   logic        handshake;
   logic        resp_live;

   logic        last_q, last_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_id_q, resp_id_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] err_addr_q, err_addr_d;
   logic [7:0]  err_count_q, err_count_d;

   logic        rsp_rvalid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   assign m0_legal = (m0_addr_i >= SRAM_BASE_ADDR) && (m0_addr_i < SRAM_END_ADDR);
   assign m1_legal = (m1_addr_i >= SRAM_BASE_ADDR) && (m1_addr_i < SRAM_END_ADDR);

   // Winner selection and grant. On a tie the master that did not win the
   // last handshake goes first. Illegal winners are accepted locally.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path leaves
      // it unassigned; otherwise synthesis would infer a latch.
      win_id    = 1'b0;
      win_req   = m0_req_i | m1_req_i;
      win_legal = 1'b0;
      handshake = 1'b0;
      if (m0_req_i && m1_req_i) begin
         win_id = ~last_q;
      end else begin
         win_id = m1_req_i;
      end
      win_legal = win_id ? m1_legal : m0_legal;
      handshake = win_req && (win_legal ? sram_d_gnt_i : 1'b1);
   end

   assign m0_gnt_o = handshake && !win_id;
   assign m1_gnt_o = handshake &&  win_id;

   // Downstream request: only legal winners are forwarded; payload is zeroed
   // otherwise so the SRAM never sees stale or illegal addresses.
   always_comb begin
      sram_d_req_o   = 1'b0;
      sram_d_addr_o  = 32'h0;
      sram_d_we_o    = 1'b0;
      sram_d_be_o    = 4'h0;
      sram_d_wdata_o = 32'h0;
      if (win_req && win_legal) begin
         sram_d_req_o = 1'b1;
         if (win_id) begin
            sram_d_addr_o  = m1_addr_i;
            sram_d_we_o    = m1_we_i;
            sram_d_be_o    = m1_be_i;
            sram_d_wdata_o = m1_wdata_i;
         end else begin
            sram_d_addr_o  = m0_addr_i;
            sram_d_we_o    = m0_we_i;
            sram_d_be_o    = m0_be_i;
            sram_d_wdata_o = m0_wdata_i;
         end
      end
   end

   // Next state. A response slot is opened on every handshake and closed
   // otherwise; the SRAM's fixed 1-cycle latency means one slot is enough.
   always_comb begin
      last_d       = last_q;
      resp_valid_d = handshake;
      resp_id_d    = resp_id_q;
      resp_err_d   = resp_err_q;
      err_addr_d   = err_addr_q;
      err_count_d  = err_count_q;
      if (handshake) begin
         last_d     = win_id;
         resp_id_d  = win_id;
         resp_err_d = !win_legal;
         if (!win_legal) begin
            err_addr_d = win_id ? m1_addr_i : m0_addr_i;
            if (err_count_q != 8'hFF) begin
               err_count_d = err_count_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!rst_ni) begin
         // NOTE: only control/status registers exist here and all of them are
         // reset; there is no storage array that could be left unreset.
         last_q       <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         resp_err_q   <= 1'b0;
         err_addr_q   <= 32'h0;
         err_count_q  <= 8'h0;
      end else begin
         last_q       <= last_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_err_q   <= resp_err_d;
         err_addr_q   <= err_addr_d;
         err_count_q  <= err_count_d;
      end
   end

   // Asserting reset in the response cycle drops the response at once, so
   // a downstream rvalid arriving in that cycle never reaches a master.
   assign resp_live = resp_valid_q && rst_ni;

   always_comb begin
      rsp_rvalid       = 1'b0;
      rsp_rdata        = 32'h0;
      rsp_err          = 1'b0;
      illegal_memory_o = 1'b0;
      if (resp_live) begin
         if (resp_err_q) begin
            rsp_rvalid       = 1'b1;
            rsp_err          = 1'b1;
            illegal_memory_o = 1'b1;
         end else begin
            rsp_rvalid = sram_d_rvalid_i;
            rsp_rdata  = sram_d_rdata_i;
         end
      end
   end

   // Route the single response to its master; the other sees all zeros.
   assign m0_rvalid_o = rsp_rvalid && !resp_id_q;
   assign m0_rdata_o  = resp_id_q ? 32'h0 : rsp_rdata;
   assign m0_err_o    = rsp_err && !resp_id_q;
   assign m1_rvalid_o = rsp_rvalid && resp_id_q;
   assign m1_rdata_o  = resp_id_q ? rsp_rdata : 32'h0;
   assign m1_err_o    = rsp_err && resp_id_q;

   assign err_addr_o  = err_addr_q;
   assign err_count_o = err_count_q;

endmodule

// File: tb/tb_sram_d_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sram_d_arbiter
//
// Table-driven bench for sram_d_arbiter. Each vector drives one cycle and
// carries the expected grants and forwarding. Every expected handshake pushes
// an expected response to a scoreboard queue. The entry is popped and compared
// in the following cycle, when the DUT must deliver it. A stub SRAM answers
// forwarded handshakes one cycle later with address-derived data.
// -----------------------------------------------------------------------------
module tb_sram_d_arbiter;

   localparam logic [31:0] A_ADDR    = 32'h8000_0010;
   localparam logic [31:0] B_ADDR    = 32'h8000_0020;
   localparam logic [31:0] BAD_ADDR  = 32'h8000_C000;
   localparam logic [31:0] EDGE_ADDR = 32'h8000_BFFC;
   localparam logic [31:0] LOW_ADDR  = 32'h7FFF_FFFC;

   typedef struct {
      logic        rst_n;
      logic        m0_req;
      logic [31:0] m0_addr;
      logic        m0_we;
      logic        m1_req;
      logic [31:0] m1_addr;
      logic        m1_we;
      logic        gnt;
      logic        e_m0_gnt;
      logic        e_m1_gnt;
      logic        e_req;
      logic        e_win;
   } vec_t;

   typedef struct {
      logic        id;
      logic        err;
      logic [31:0] data;
      logic [31:0] addr;
   } resp_t;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
   logic [31:0] m0_addr_i = '0, m1_addr_i = '0;
   logic        m0_we_i = 1'b0, m1_we_i = 1'b0;
   logic [3:0]  m0_be_i = 4'hF, m1_be_i = 4'h3;
   logic [31:0] m0_wdata_i = '0, m1_wdata_i = '0;
   logic        m0_gnt_o, m1_gnt_o;
   logic        m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        sram_d_req_o, sram_d_we_o;
   logic        sram_d_gnt_i = 1'b1;
   logic [31:0] sram_d_addr_o, sram_d_wdata_o;
   logic [3:0]  sram_d_be_o;
   logic        sram_d_rvalid_i;
   logic [31:0] sram_d_rdata_i;
   logic        illegal_memory_o;
   logic [31:0] err_addr_o;
   logic [7:0]  err_count_o;

   logic        stub_rv = 1'b0;
   logic [31:0] stub_rd = '0;
   logic        spur = 1'b0;

   int          errors = 0;
   int          checks = 0;
   resp_t       sb[$];
   vec_t        tbl[$];
   logic [7:0]  exp_cnt = 8'h0;
   logic [31:0] exp_eaddr = 32'h0;

   sram_d_arbiter dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .m0_req_i         (m0_req_i),
      .m0_gnt_o         (m0_gnt_o),
      .m0_addr_i        (m0_addr_i),
      .m0_we_i          (m0_we_i),
      .m0_be_i          (m0_be_i),
      .m0_wdata_i       (m0_wdata_i),
      .m0_rvalid_o      (m0_rvalid_o),
      .m0_rdata_o       (m0_rdata_o),
      .m0_err_o         (m0_err_o),
      .m1_req_i         (m1_req_i),
      .m1_gnt_o         (m1_gnt_o),
      .m1_addr_i        (m1_addr_i),
      .m1_we_i          (m1_we_i),
      .m1_be_i          (m1_be_i),
      .m1_wdata_i       (m1_wdata_i),
      .m1_rvalid_o      (m1_rvalid_o),
      .m1_rdata_o       (m1_rdata_o),
      .m1_err_o         (m1_err_o),
      .sram_d_req_o     (sram_d_req_o),
      .sram_d_gnt_i     (sram_d_gnt_i),
      .sram_d_addr_o    (sram_d_addr_o),
      .sram_d_we_o      (sram_d_we_o),
      .sram_d_be_o      (sram_d_be_o),
      .sram_d_wdata_o   (sram_d_wdata_o),
      .sram_d_rvalid_i  (sram_d_rvalid_i),
      .sram_d_rdata_i   (sram_d_rdata_i),
      .illegal_memory_o (illegal_memory_o),
      .err_addr_o       (err_addr_o),
      .err_count_o      (err_count_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] stub_data(input logic [31:0] a);
      return (a == A_ADDR) ? 32'h1234_5678 : (a ^ 32'h5A5A_5A5A);
   endfunction

   // Stub SRAM: fixed 1-cycle response to every forwarded handshake. It
   // ignores reset, so it still answers in a cycle where reset is asserted.
   // 'spur' injects an rvalid that no handshake asked for.
   always @(posedge clk_i) begin
      stub_rv <= sram_d_req_o && sram_d_gnt_i;
      stub_rd <= (sram_d_req_o && sram_d_gnt_i) ? stub_data(sram_d_addr_o) : 32'hDEAD_BEEF;
   end
   assign sram_d_rvalid_i = stub_rv | spur;
   assign sram_d_rdata_i  = stub_rd;

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic rst_n, input logic r0, input logic [31:0] a0,
                               input logic w0, input logic r1, input logic [31:0] a1,
                               input logic w1, input logic g, input logic e0, input logic e1,
                               input logic er, input logic ew);
      vec_t v;
      v.rst_n = rst_n; v.m0_req = r0; v.m0_addr = a0; v.m0_we = w0;
      v.m1_req = r1; v.m1_addr = a1; v.m1_we = w1; v.gnt = g;
      v.e_m0_gnt = e0; v.e_m1_gnt = e1; v.e_req = er; v.e_win = ew;
      return v;
   endfunction

   function automatic vec_t idle();
      return mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   // One cycle: drive after the edge, compare at the falling edge.
   task automatic apply(input vec_t v);
      resp_t       r;
      logic        have;
      logic [31:0] ea, ed;
      logic        ew;
      logic [3:0]  eb;
      r = '{id: 1'b0, err: 1'b0, data: 32'h0, addr: 32'h0};
      @(posedge clk_i);
      #1;
      rst_ni       = v.rst_n;
      m0_req_i     = v.m0_req;
      m0_addr_i    = v.m0_addr;
      m0_we_i      = v.m0_we;
      m0_wdata_i   = v.m0_addr ^ 32'h0F0F_0F0F;
      m1_req_i     = v.m1_req;
      m1_addr_i    = v.m1_addr;
      m1_we_i      = v.m1_we;
      m1_wdata_i   = v.m1_addr ^ 32'hF0F0_F0F0;
      sram_d_gnt_i = v.gnt;
      #4;
      // Reset in the response cycle drops whatever was in flight.
      if (!v.rst_n) sb.delete();
      have = (sb.size() != 0);
      if (have) begin
         r = sb.pop_front();
         if (r.err) begin
            exp_eaddr = r.addr;
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
         end
      end
      check1 ("m0_rvalid", m0_rvalid_o, have && !r.id);
      check1 ("m0_err",    m0_err_o,    have && !r.id && r.err);
      check32("m0_rdata",  m0_rdata_o,  (have && !r.id) ? r.data : 32'h0);
      check1 ("m1_rvalid", m1_rvalid_o, have && r.id);
      check1 ("m1_err",    m1_err_o,    have && r.id && r.err);
      check32("m1_rdata",  m1_rdata_o,  (have && r.id) ? r.data : 32'h0);
      check1 ("illegal_memory", illegal_memory_o, have && r.err);
      if (v.rst_n) begin
         check32("err_addr",  err_addr_o,       exp_eaddr);
         check32("err_count", 32'(err_count_o), 32'(exp_cnt));
      end
      check1("m0_gnt",   m0_gnt_o,     v.e_m0_gnt);
      check1("m1_gnt",   m1_gnt_o,     v.e_m1_gnt);
      check1("sram_req", sram_d_req_o, v.e_req);
      ea = 32'h0; ed = 32'h0; ew = 1'b0; eb = 4'h0;
      if (v.e_req) begin
         if (v.e_win) begin
            ea = v.m1_addr; ed = v.m1_addr ^ 32'hF0F0_F0F0; ew = v.m1_we; eb = 4'h3;
         end else begin
            ea = v.m0_addr; ed = v.m0_addr ^ 32'h0F0F_0F0F; ew = v.m0_we; eb = 4'hF;
         end
      end
      check32("sram_addr",  sram_d_addr_o,    ea);
      check1 ("sram_we",    sram_d_we_o,      ew);
      check32("sram_be",    32'(sram_d_be_o), 32'(eb));
      check32("sram_wdata", sram_d_wdata_o,   ed);
      if (!v.rst_n) begin
         exp_cnt   = 8'h0;
         exp_eaddr = 32'h0;
      end else if (v.e_m0_gnt || v.e_m1_gnt) begin
         r.id   = v.e_m1_gnt;
         r.err  = !v.e_req;
         r.addr = v.e_m1_gnt ? v.m1_addr : v.m0_addr;
         r.data = v.e_req ? stub_data(r.addr) : 32'h0;
         sb.push_back(r);
      end
   endtask

   initial begin
      // rst, r0, a0, w0, r1, a1, w1, gnt, e_m0_gnt, e_m1_gnt, e_req, e_win
      tbl.push_back(mk(0, 0, 32'h0,     0, 0, 32'h0,     0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 32'h0,     0, 0, 32'h0,     0, 1, 0, 0, 0, 0));
      tbl.push_back(idle());                                               // reset state
      tbl.push_back(mk(1, 1, A_ADDR,    0, 1, B_ADDR,    1, 1, 1, 0, 1, 0)); // contention: m0
      tbl.push_back(mk(1, 1, A_ADDR,    0, 1, B_ADDR,    1, 1, 0, 1, 1, 1)); // m1
      tbl.push_back(mk(1, 1, A_ADDR,    0, 1, B_ADDR,    1, 1, 1, 0, 1, 0)); // m0
      tbl.push_back(mk(1, 1, A_ADDR,    0, 1, B_ADDR,    1, 1, 0, 1, 1, 1)); // m1
      tbl.push_back(idle());
      tbl.push_back(mk(1, 1, A_ADDR,    0, 0, 32'h0,     0, 1, 1, 0, 1, 0)); // single read
      tbl.push_back(idle());
      tbl.push_back(mk(1, 0, 32'h0,     0, 1, BAD_ADDR,  1, 1, 0, 1, 0, 1)); // illegal write
      tbl.push_back(idle());
      tbl.push_back(mk(1, 1, EDGE_ADDR, 0, 0, 32'h0,     0, 1, 1, 0, 1, 0)); // top edge legal
      tbl.push_back(mk(1, 0, 32'h0,     0, 1, LOW_ADDR,  0, 1, 0, 1, 0, 1)); // below base
      tbl.push_back(mk(1, 1, BAD_ADDR,  0, 1, B_ADDR,    0, 1, 1, 0, 0, 0)); // illegal wins tie
      tbl.push_back(mk(1, 1, BAD_ADDR,  0, 1, B_ADDR,    0, 1, 0, 1, 1, 1)); // legal m1 next
      tbl.push_back(idle());
      tbl.push_back(mk(1, 1, A_ADDR,    0, 1, B_ADDR,    0, 0, 0, 0, 1, 0)); // stalled tie

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // Downstream stall: three cycles without gnt, then accepted.
      for (int i = 0; i < 3; i++)
         apply(mk(1, 1, A_ADDR, 0, 0, 32'h0, 0, 0, 0, 0, 1, 0));
      apply(mk(1, 1, A_ADDR, 0, 0, 32'h0, 0, 1, 1, 0, 1, 0));
      apply(idle());

      // Spurious downstream rvalid: ignored when idle, and never leaks data
      // into an error response.
      spur = 1'b1;
      apply(idle());
      apply(mk(1, 0, 32'h0, 0, 1, BAD_ADDR, 1, 1, 0, 1, 0, 1));
      apply(idle());
      apply(idle());
      spur = 1'b0;

      // 300 back-to-back illegal requests: the count saturates, the address
      // keeps tracking.
      for (int i = 0; i < 300; i++)
         apply(mk(1, 1, (i % 2 == 0) ? LOW_ADDR : BAD_ADDR, 0, 0, 32'h0, 0, 1, 1, 0, 0, 0));
      apply(idle());
      check32("err_count_saturated", 32'(err_count_o), 32'd255);
      check32("err_addr_after_sat",  err_addr_o,       BAD_ADDR);

      // Reset in the cycle after a legal handshake: response dropped, and the
      // round-robin pointer returns so m0 wins the next tie.
      apply(mk(1, 1, A_ADDR, 0, 0, 32'h0,  0, 1, 1, 0, 1, 0));
      apply(mk(0, 0, 32'h0,  0, 0, 32'h0,  0, 1, 0, 0, 0, 0));
      apply(mk(1, 1, A_ADDR, 0, 1, B_ADDR, 0, 1, 1, 0, 1, 0));
      apply(idle());
      check32("err_count_after_reset", 32'(err_count_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
